// File: rtl/stim_sequencer.sv
// Stimulus replay engine: plays a RAM-held vector program onto a DUT input bus.
// The read path is RAM read register (_p0) followed by the registered vec_out stage.
module stim_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              loop_mode,
  input  logic [ADDR_W:0]   length,
  output logic [WIDTH-1:0]  vec_out,
  output logic              vec_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [15:0]       loop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_ram [DEPTH];
  logic [WIDTH-1:0]  r_rd_p0;
  logic              r_vld_p0;
  logic [WIDTH-1:0]  r_vec;
  logic              r_vec_vld;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W:0]   r_len;
  logic              r_loop;
  logic              r_drain;
  logic [15:0]       r_loop_cnt;
  logic              r_done;

  logic              w_adv;
  logic              w_issue;
  logic              w_last;
  logic              w_start;
  logic              w_stop;
  logic [ADDR_W:0]   w_len;

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    if (len > (ADDR_W+1)'(DEPTH)) return (ADDR_W+1)'(DEPTH);
    return len;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // w_adv moves the whole pipeline; hold freezes both the read issue and the output landing.
  always_comb begin
    w_adv       = (r_state == S_RUN) && !stop && !hold;
    w_issue     = w_adv && !r_drain;
    w_last      = w_issue && ({1'b0, r_pc} == (r_len - (ADDR_W+1)'(1)));
    w_start     = (r_state == S_IDLE) && start;
    w_stop      = (r_state == S_RUN) && stop;
    w_len       = clamp_len(length);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (w_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (stop)                 w_state_nxt = S_IDLE;
        else if (r_drain && !hold) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // p0: vector RAM write port and synchronous read register
  always_ff @(posedge clock) begin
    if (wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH))) r_ram[wr_addr] <= wr_data;
    if (w_issue) r_rd_p0 <= r_ram[r_pc];
  end

  // p1: control state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_len      <= '0;
      r_loop     <= 1'b0;
      r_drain    <= 1'b0;
      r_vld_p0   <= 1'b0;
      r_loop_cnt <= '0;
      r_done     <= 1'b0;
      r_vec      <= '0;
      r_vec_vld  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= (r_state == S_DONE);
      r_vec_vld <= r_vld_p0 && w_adv;
      if (r_vld_p0 && w_adv) r_vec <= r_rd_p0;

      if (w_stop)                          r_vld_p0 <= 1'b0;
      else if (w_adv || r_state != S_RUN) r_vld_p0 <= w_issue;

      // One drain cycle after the final read lets the last vector land before DONE.
      if (w_stop)     r_drain <= 1'b0;
      else if (w_adv) r_drain <= w_last && !r_loop;

      if (w_start) begin
        r_len      <= w_len;
        r_loop     <= loop_mode;
        r_pc       <= '0;
        r_loop_cnt <= '0;
      end else if (w_issue) begin
        if (w_last && r_loop) begin
          r_pc       <= '0;
          r_loop_cnt <= sat_inc(r_loop_cnt);
        end else begin
          r_pc <= r_pc + ADDR_W'(1);
        end
      end
    end
  end

  assign vec_out   = r_vec;
  assign vec_valid = r_vec_vld;
  assign pc        = r_pc;
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign loop_cnt  = r_loop_cnt;

endmodule

// File: tb/tb_stim_sequencer.sv
// Table-driven bench for stim_sequencer plus hand sequences for length clamp and live RAM writes.
module tb_stim_sequencer;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              start;
  logic              stop;
  logic              hold;
  logic              loop_mode;
  logic [ADDR_W:0]   length;
  logic [WIDTH-1:0]  vec_out;
  logic              vec_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic [15:0]       loop_cnt;

  stim_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .hold(hold), .loop_mode(loop_mode), .length(length),
    .vec_out(vec_out), .vec_valid(vec_valid), .pc(pc), .busy(busy), .done(done),
    .loop_cnt(loop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, st, sp, hd, lp;
    logic [4:0]  len;
    logic [7:0]  vec;
    logic        vld, bsy, dn;
    logic [15:0] cnt;
    logic [3:0]  pc;
  } row_t;

  row_t       tbl[$];
  logic [7:0] mem_m [16];
  logic [7:0] exp6 [6] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h99, 8'h33};
  logic [7:0] got[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n;
  logic       seen;

  function automatic row_t mk(input logic rst, st, sp, hd, lp, input logic [4:0] len,
                              input logic [7:0] vec, input logic vld, bsy, dn,
                              input logic [15:0] cnt, input logic [3:0] p);
    row_t r;
    r.rst = rst; r.st = st; r.sp = sp; r.hd = hd; r.lp = lp; r.len = len;
    r.vec = vec; r.vld = vld; r.bsy = bsy; r.dn = dn; r.cnt = cnt; r.pc = p;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; hold = 1'b0; loop_mode = 1'b0; length = '0;
    mem_m[0] = 8'h11; mem_m[1] = 8'h22; mem_m[2] = 8'h33; mem_m[3] = 8'h44;
    for (int i = 4; i < 16; i++) mem_m[i] = 8'h50 + 8'(i);
    tick;
    for (int i = 0; i < 16; i++) wr(4'(i), mem_m[i]);

    //         rst st sp hd lp len  vec   vld bsy dn cnt pc
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));   // reset state
    tbl.push_back(mk(0, 1, 0, 0, 0, 4, 8'h00, 0, 1, 0, 0, 0));   // one-shot, length 4
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h22, 1, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 1, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h44, 1, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h44, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h44, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4, 8'h44, 0, 1, 0, 0, 0));   // hold after 22h
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h44, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h22, 1, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h22, 0, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h22, 0, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 1, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h44, 1, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h44, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 8'h44, 0, 1, 0, 0, 0));   // loop, length 3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h44, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h22, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h22, 1, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 1, 1, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h33, 0, 0, 0, 2, 1));   // stop
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'h33, 0, 0, 0, 0, 0));   // start+stop, length 0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4, 8'h33, 0, 1, 0, 0, 0));   // reset mid-run
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h11, 0, 0, 0, 0, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; start = tbl[i].st; stop = tbl[i].sp;
      hold = tbl[i].hd; loop_mode = tbl[i].lp; length = tbl[i].len;
      tick;
      chk("vec_out",   i, 32'(vec_out),   32'(tbl[i].vec));
      chk("vec_valid", i, 32'(vec_valid), 32'(tbl[i].vld));
      chk("busy",      i, 32'(busy),      32'(tbl[i].bsy));
      chk("done",      i, 32'(done),      32'(tbl[i].dn));
      chk("loop_cnt",  i, 32'(loop_cnt),  32'(tbl[i].cnt));
      chk("pc",        i, 32'(pc),        32'(tbl[i].pc));
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; loop_mode = 1'b0; length = '0;
    tick;

    // Length above DEPTH is clamped: exactly 16 vectors, in RAM order.
    start = 1'b1; length = 5'd20; loop_mode = 1'b0;
    tick;
    start = 1'b0;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick;
      if (vec_valid) begin
        if (n < 16) chk("len20_vec", n, 32'(vec_out), 32'(mem_m[n]));
        n++;
      end
      if (done) seen = 1'b1;
    end
    chk("len20_count", 0, n, 16);
    chk("len20_done", 0, 32'(seen), 1);
    chk("len20_busy", 0, 32'(busy), 0);
    tick;

    // Loop with a same-cycle write to the entry being read, and a start while busy.
    start = 1'b1; length = 5'd3; loop_mode = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("t6_pc", 0, 32'(pc), 1);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h99; start = 1'b1; length = 5'd4; loop_mode = 1'b0;
    tick;
    wr_en = 1'b0; start = 1'b0;
    got.delete();
    if (vec_valid) got.push_back(vec_out);
    for (int c = 0; c < 20 && got.size() < 6; c++) begin
      tick;
      if (vec_valid) got.push_back(vec_out);
    end
    chk("t6_count", 0, got.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < got.size()) chk("t6_vec", k, 32'(got[k]), 32'(exp6[k]));
    chk("t6_busy", 0, 32'(busy), 1);
    chk("t6_loop_cnt", 0, 32'(loop_cnt), 2);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("t6_stop_busy", 0, 32'(busy), 0);
    chk("t6_stop_valid", 0, 32'(vec_valid), 0);
    tick;
    chk("t6_stop_done", 0, 32'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
